muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Multi-cycle RV32M multiply/divide unit; producer side of the muldiv pending/fire writeback handshake.
//  Accepts one op from EX, computes it, then holds muldiv_pending with hart/rd/result until the WB arbiter
//  asserts muldiv_wb_fire. Single outstanding op; busy back-pressures issue.
// PARAMETERS
//  XLEN        32  operand/result width
//  HART_ID_W   2   hart id width
//  REG_ADDR_W  5   register address width
//  MUL_LAT     2   start-to-pending latency of multiply ops, >=1
// PORTS
//  clk                     in   1           clock, rising edge
//  rst_n                   in   1           asynchronous reset, active low
//  start                   in   1           issue op; accepted only when busy=0
//  op                      in   3           RV32M funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  hart_id                 in   HART_ID_W   issuing hart
//  rd                      in   REG_ADDR_W  destination register
//  rs1, rs2                in   XLEN        operands
//  busy                    out  1           unit occupied (state != IDLE)
//  muldiv_pending          out  1           result valid, awaiting writeback
//  muldiv_pending_hart_id  out  HART_ID_W   hart of pending result
//  muldiv_pending_rd       out  REG_ADDR_W  rd of pending result
//  muldiv_pending_result   out  XLEN        pending result
//  muldiv_wb_fire          in   1           WB consumed pending result this cycle
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; busy, muldiv_pending, hart_id/rd/result outputs all 0; any op in flight discarded.
//  States: IDLE, MUL, DIV, DONE. busy=1 in MUL/DIV/DONE; muldiv_pending=1 exactly in DONE.
//  IDLE: start=1 latches op/hart_id/rd/rs1/rs2 at edge T. op<4 -> MUL with counter=MUL_LAT-1.
//   op>=4 and divisor 0 -> DONE (fast path). Signed op, rs1=0x80000000, rs2=0xFFFFFFFF -> DONE (fast path).
//   else -> DIV: operands converted to magnitudes, counter=XLEN.
//  MUL: counter decrements each cycle; at 0 -> DONE. Pending first visible cycle T+MUL_LAT.
//   Full 2*XLEN product; MUL low half; MULH s*s, MULHSU s*u (rs1 signed), MULHU u*u high half.
//  DIV: radix-2 restoring, one quotient bit per cycle, XLEN iterations, then one fixup cycle applying signs:
//   quotient negated if operand signs differ (signed ops); remainder takes sign of dividend.
//   Pending first visible T+XLEN+1. DIV/DIVU select quotient, REM/REMU remainder.
//  Fast path result (pending at T+1): div-by-0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU rs1;
//   overflow -> DIV 0x80000000, REM 0.
//  DONE: outputs stable until muldiv_wb_fire=1; on fire -> IDLE next edge, pending/busy drop next cycle.
//   start while busy (incl. the fire cycle) is ignored; issuer must retry once busy=0.
//  rd=0 still produces a pending result; arbiter fires it without using the port.
//  muldiv_wb_fire outside DONE is ignored. Pending outputs hold last values while not pending (0 after reset).
// TESTING
//  MUL rs1=7 rs2=0xFFFFFFFD, start@T -> pending@T+2, result 0xFFFFFFEB; fire -> busy=0 next cycle.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD at T+33; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
//  DIVU x/0 -> 0xFFFFFFFF at T+1; REM 0x80000000/0xFFFFFFFF -> 0 at T+1; DIV same -> 0x80000000.
//  Hold fire low 10 cycles after pending -> pending, hart, rd, result unchanged; start during hold ignored.
//  Assert rst_n=0 mid-DIV (cycle T+10) -> busy/pending 0 immediately; after release new MUL completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M multiply/divide unit that produces the muldiv pending/fire writeback handshake.
// Latency from the start edge: divide-by-zero and signed overflow finish at +1, multiplies at +MUL_LAT, and other divides at +XLEN+1.
// Backpressure: busy stays high from the accepting edge until writeback fires. Any start seen while busy is dropped, so the issuer must retry.
//
// Ports:
//   clk, rst_n               clock (rising edge); asynchronous active-low reset
//   start, op                issue strobe and RV32M funct3 (0 MUL .. 7 REMU); accepted only when busy=0
//   hart_id, rd              issuing hart and destination register, carried through to the pending result
//   rs1, rs2                 operands
//   busy                     unit occupied (MUL, DIV or DONE)
//   muldiv_pending           result valid and waiting for writeback (DONE state)
//   muldiv_pending_hart_id   hart of the pending result (holds its last value when not pending)
//   muldiv_pending_rd        rd of the pending result (holds its last value when not pending)
//   muldiv_pending_result    pending result (holds its last value when not pending)
//   muldiv_wb_fire           writeback consumed the pending result this cycle; ignored outside DONE
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int HART_ID_W  = 2,
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [HART_ID_W-1:0]  hart_id,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       rs1,
  input  logic [XLEN-1:0]       rs2,
  output logic                  busy,
  output logic                  muldiv_pending,
  output logic [HART_ID_W-1:0]  muldiv_pending_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_pending_rd,
  output logic [XLEN-1:0]       muldiv_pending_result,
  input  logic                  muldiv_wb_fire
);

  localparam int CNT_W = $clog2(XLEN + MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_DIV = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [XLEN-1:0]  INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [2:0]              op_q;
  logic [HART_ID_W-1:0]    hart_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  // a_q holds rs1 for multiplies. For divides it holds the dividend magnitude, which shifts out as quotient bits shift in.
  logic [XLEN-1:0]         a_q;
  logic [XLEN-1:0]         b_q;
  logic [XLEN-1:0]         rem_q;
  logic                    q_neg_q;
  logic                    r_neg_q;
  logic                    busy_q;
  logic                    pend_q;
  logic [HART_ID_W-1:0]    pend_hart_q;
  logic [REG_ADDR_W-1:0]   pend_rd_q;
  logic [XLEN-1:0]         pend_res_q;

  // Sign-extend each operand to 2*XLEN according to the op. The low 2*XLEN bits of the
  // unsigned product are then the correct signed, mixed or unsigned product.
  function automatic logic [XLEN-1:0] mul_calc(input logic [2:0] f,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic              a_sx;
    logic              b_sx;
    logic [2*XLEN-1:0] a_ext;
    logic [2*XLEN-1:0] b_ext;
    logic [2*XLEN-1:0] prod;
    a_sx  = ((f == 3'd1) || (f == 3'd2)) && a[XLEN-1];
    b_sx  = (f == 3'd1) && b[XLEN-1];
    a_ext = {{XLEN{a_sx}}, a};
    b_ext = {{XLEN{b_sx}}, b};
    prod  = a_ext * b_ext;
    return (f == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  // Issue-side decode. For divide ops, op[0]=1 means unsigned and op[1]=1 means remainder.
  logic            in_signed;
  logic            in_rem;
  logic            in_div0;
  logic            in_ovf;
  logic            in_fast;
  logic [XLEN-1:0] fast_res;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] mul_res_in;
  logic [XLEN-1:0] mul_res_q;

  always_comb begin
    in_signed = ~op[0];
    in_rem    = op[1];
    in_div0   = (rs2 == '0);
    in_ovf    = in_signed && (rs1 == INT_MIN) && (rs2 == '1);
    in_fast   = op[2] && (in_div0 || in_ovf);
    if (in_div0) begin
      fast_res = in_rem ? rs1 : '1;
    end else begin
      fast_res = in_rem ? '0 : INT_MIN;
    end
    a_mag = (in_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    b_mag = (in_signed && rs2[XLEN-1]) ? -rs2 : rs2;
  end

  // MUL_LAT==1 finishes straight from IDLE, so it needs the product of the live operands.
  assign mul_res_in = mul_calc(op, rs1, rs2);
  assign mul_res_q  = mul_calc(op_q, a_q, b_q);

  // One restoring-division step: shift the next dividend bit into the partial remainder,
  // then keep the subtraction only if it did not borrow.
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic [XLEN-1:0] div_res;

  always_comb begin
    rem_sh  = {rem_q, a_q[XLEN-1]};
    diff    = rem_sh - {1'b0, b_q};
    q_bit   = ~diff[XLEN];
    rem_d   = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_d   = {a_q[XLEN-2:0], q_bit};
    // Sign fixup is applied to the final step's values. The result then lands in DONE on
    // the same edge as the last quotient bit, instead of one edge later.
    q_fix   = q_neg_q ? -quo_d : quo_d;
    r_fix   = r_neg_q ? -rem_d : rem_d;
    div_res = op_q[1] ? r_fix : q_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      hart_q      <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      busy_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_hart_q <= '0;
      pend_rd_q   <= '0;
      pend_res_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            hart_q <= hart_id;
            rd_q   <= rd;
            busy_q <= 1'b1;
            if (!op[2]) begin
              a_q <= rs1;
              b_q <= rs2;
              if (MUL_LAT == 1) begin
                state_q     <= S_DONE;
                pend_q      <= 1'b1;
                pend_res_q  <= mul_res_in;
                pend_hart_q <= hart_id;
                pend_rd_q   <= rd;
              end else begin
                state_q <= S_MUL;
                cnt_q   <= CNT_MUL;
              end
            end else if (in_fast) begin
              state_q     <= S_DONE;
              pend_q      <= 1'b1;
              pend_res_q  <= fast_res;
              pend_hart_q <= hart_id;
              pend_rd_q   <= rd;
            end else begin
              state_q <= S_DIV;
              cnt_q   <= CNT_DIV;
              a_q     <= a_mag;
              b_q     <= b_mag;
              rem_q   <= '0;
              q_neg_q <= in_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
              r_neg_q <= in_signed && rs1[XLEN-1];
            end
          end
        end

        S_MUL: begin
          // When the counter would decrement to zero, the product is captured and DONE is entered.
          if (cnt_q == CNT_ONE) begin
            state_q     <= S_DONE;
            pend_q      <= 1'b1;
            pend_res_q  <= mul_res_q;
            pend_hart_q <= hart_q;
            pend_rd_q   <= rd_q;
          end
          cnt_q <= cnt_q - CNT_ONE;
        end

        S_DIV: begin
          a_q   <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q     <= S_DONE;
            pend_q      <= 1'b1;
            pend_res_q  <= div_res;
            pend_hart_q <= hart_q;
            pend_rd_q   <= rd_q;
          end
        end

        S_DONE: begin
          if (muldiv_wb_fire) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy                   = busy_q;
  assign muldiv_pending         = pend_q;
  assign muldiv_pending_hart_id = pend_hart_q;
  assign muldiv_pending_rd      = pend_rd_q;
  assign muldiv_pending_result  = pend_res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. It uses directed RV32M cases, a hold/ignored-start case,
// an asynchronous reset in the middle of a divide, and randomized ops checked against an arithmetic reference.
// Bench timing convention: latency is counted from the accepting edge, which is numbered 1.
module tb_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  hart_id = '0;
  logic [4:0]  rd = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        muldiv_pending;
  logic [1:0]  p_hart;
  logic [4:0]  p_rd;
  logic [31:0] p_res;
  logic        muldiv_wb_fire = 1'b0;

  muldiv_unit #(.XLEN(XLEN), .HART_ID_W(2), .REG_ADDR_W(5), .MUL_LAT(MUL_LAT)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .start                  (start),
    .op                     (op),
    .hart_id                (hart_id),
    .rd                     (rd),
    .rs1                    (rs1),
    .rs2                    (rs2),
    .busy                   (busy),
    .muldiv_pending         (muldiv_pending),
    .muldiv_pending_hart_id (p_hart),
    .muldiv_pending_rd      (p_rd),
    .muldiv_pending_result  (p_res),
    .muldiv_wb_fire         (muldiv_wb_fire)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  bit abort    = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  hart;
    logic [4:0]  rd;
    int          lat;
    int          start_cyc;
    int          hold;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain 64-bit arithmetic plus the RV32M special cases.
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          sp;
    longint unsigned up;
    int              ia;
    int              ib;
    bit              ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * longint'({32'h0, b}); return sp[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return MUL_LAT;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", n);
      abort = 1'b1;
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int hold, input bit push);
    exp_t e;
    @(negedge clk);
    wait_idle();
    if (abort) return;
    start   = 1'b1;
    op      = f;
    rs1     = a;
    rs2     = b;
    hart_id = 2'($urandom);
    rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    e.res       = res;
    e.hart      = hart_id;
    e.rd        = rd;
    e.lat       = ref_lat(f, a, b);
    e.start_cyc = cyc + 1;
    e.hold      = hold;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Monitor / writeback-arbiter side: pops the scoreboard when a result first appears, checks it stays
  // stable while the bench holds fire low, then fires and checks the unit drops busy/pending the next cycle.
  // While busy with no result pending, it sometimes raises a stray fire, which the unit must ignore.
  bit   in_pend = 1'b0;
  bit   stray   = 1'b0;
  int   hold_left = 0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pend        = 1'b0;
        stray          = 1'b0;
        muldiv_wb_fire = 1'b0;
        continue;
      end
      if (muldiv_wb_fire && !stray) begin
        muldiv_wb_fire = 1'b0;
        in_pend        = 1'b0;
        check("busy_after_fire", 32'(busy), 32'd0);
        check("pending_after_fire", 32'(muldiv_pending), 32'd0);
        continue;
      end
      if (muldiv_wb_fire && stray) begin
        muldiv_wb_fire = 1'b0;
        stray          = 1'b0;
      end
      if (in_pend) begin
        check("hold_pending", 32'(muldiv_pending), 32'd1);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_result", p_res, cur.res);
        check("hold_hart", 32'(p_hart), 32'(cur.hart));
        check("hold_rd", 32'(p_rd), 32'(cur.rd));
      end else if (muldiv_pending) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pending: result 0x%08h appeared, expected no result", p_res);
          cur.hold = 0;
        end else begin
          cur = exp_q.pop_front();
          check("result", p_res, cur.res);
          check("pending_hart", 32'(p_hart), 32'(cur.hart));
          check("pending_rd", 32'(p_rd), 32'(cur.rd));
          check("latency", 32'(cyc - cur.start_cyc + 1), 32'(cur.lat));
        end
        in_pend   = 1'b1;
        hold_left = cur.hold;
      end
      if (in_pend) begin
        if (hold_left == 0) muldiv_wb_fire = 1'b1;
        else hold_left--;
      end else if (busy && $urandom_range(0, 7) == 0) begin
        muldiv_wb_fire = 1'b1;
        stray          = 1'b1;
      end
    end
  end

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd7};
  logic [31:0] d_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000, 32'h0000_1234};
  logic [31:0] d_b   [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
  logic [31:0] d_exp [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 32'h0000_1234};

  initial begin
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    int          n;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_pending", 32'(muldiv_pending), 32'd0);
    check("reset_result", p_res, 32'd0);
    check("reset_hart", 32'(p_hart), 32'd0);
    check("reset_rd", 32'(p_rd), 32'd0);
    rst_n = 1'b1;

    // Directed RV32M cases, including the divide-by-zero and overflow fast paths
    for (int i = 0; i < 12; i++) begin
      if (abort) break;
      issue(d_op[i], d_a[i], d_b[i], d_exp[i], int'($urandom_range(0, 2)), 1'b1);
    end

    // Fire held low for 10 cycles, with a start held high through the hold and the fire cycle
    if (!abort) begin
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 10, 1'b1);
      n = 0;
      while (!muldiv_pending && n < 100) begin
        @(negedge clk);
        n++;
      end
      start   = 1'b1;
      op      = 3'd4;
      rs1     = 32'd1000;
      rs2     = 32'd3;
      hart_id = 2'd3;
      rd      = 5'd31;
      n = 0;
      while (busy && n < 50) begin
        @(negedge clk);
        n++;
      end
      start = 1'b0;
    end

    // Asynchronous reset in the middle of a divide, followed by a normal multiply
    if (!abort) begin
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'h0, 0, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_pending", 32'(muldiv_pending), 32'd0);
      check("midrst_result", p_res, 32'd0);
      check("midrst_hart", 32'(p_hart), 32'd0);
      check("midrst_rd", 32'(p_rd), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 1'b1);
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 160; i++) begin
      if (abort) break;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      issue(f, a, b, ref_result(f, a, b), int'($urandom_range(0, 3)), 1'b1);
    end

    // Drain the scoreboard
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
